// File: rtl/mult_s4_sched_pkg.sv
// Shared definitions for the signed 4x4 multiply scheduler: operand and
// product widths, sequencer state encoding and the magnitude helper.
package mult_s4_sched_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Two's-complement magnitude; -8 maps to 4'b1000, which is read as +8
    // by the unsigned multiplier.
    function automatic logic [OPW-1:0] absVal(input logic [OPW-1:0] v);
        return v[OPW-1] ? (~v + 4'd1) : v;
    endfunction

endpackage

// File: rtl/mult_s4_sched_multu4.sv
// The existing shared combinational 4x4 unsigned multiplier.
module MultU4Bits
    import mult_s4_sched_pkg::*;
(
    input  logic [OPW-1:0]   i_a,
    input  logic [OPW-1:0]   i_b,
    output logic [PRODW-1:0] o_p
);

    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

// File: rtl/mult_s4_sched.sv
// Two-requester scheduler producing signed 4x4 -> 8-bit products on one
// shared unsigned multiplier: arbitrate, take magnitudes, multiply, fix the
// sign, then hold the result until the consumer takes it.
module mult_s4_sched
    import mult_s4_sched_pkg::*;
#(
    parameter int RR_INIT     = 0,
    parameter int ZERO_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_x0,
    input  logic [OPW-1:0]   req_y0,
    input  logic [OPW-1:0]   req_x1,
    input  logic [OPW-1:0]   req_y1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [PRODW-1:0] resp_prod,
    output logic             busy,
    output logic [7:0]       op_count
);

    state_t           r_state;
    logic             r_rr;
    logic             r_id;
    logic             r_sign;
    logic [OPW-1:0]   r_mx;
    logic [OPW-1:0]   r_my;
    logic [PRODW-1:0] r_p;
    logic [PRODW-1:0] r_prod;
    logic             r_valid;
    logic [7:0]       r_count;

    logic             w_grant;
    logic             w_accept;
    logic [OPW-1:0]   w_selX;
    logic [OPW-1:0]   w_selY;
    logic             w_zero;
    logic [OPW-1:0]   w_multA;
    logic [OPW-1:0]   w_multB;
    logic [PRODW-1:0] w_multP;

    // Arbitration, operand selection and gating of the shared multiplier inputs.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = r_rr;
            default: w_grant = 1'b0;
        endcase
        w_accept  = (r_state == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
        w_selX  = w_grant ? req_x1 : req_x0;
        w_selY  = w_grant ? req_y1 : req_y0;
        w_zero  = (ZERO_BYPASS != 0) && ((w_selX == '0) || (w_selY == '0));
        w_multA = (r_state == MUL) ? r_mx : '0;
        w_multB = (r_state == MUL) ? r_my : '0;
    end

    MultU4Bits u_mult (
        .i_a (w_multA),
        .i_b (w_multB),
        .o_p (w_multP)
    );

    // Sequencer: latches the granted operation, steps it through MUL and FIX
    // and holds the response until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rr    <= RR_INIT[0];
            r_id    <= 1'b0;
            r_sign  <= 1'b0;
            r_mx    <= '0;
            r_my    <= '0;
            r_p     <= '0;
            r_prod  <= '0;
            r_valid <= 1'b0;
            r_count <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id   <= w_grant;
                        r_sign <= w_selX[OPW-1] ^ w_selY[OPW-1];
                        r_mx   <= absVal(w_selX);
                        r_my   <= absVal(w_selY);
                        r_rr   <= ~w_grant;
                        if (w_zero) begin
                            r_prod  <= '0;
                            r_valid <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    r_p     <= w_multP;
                    r_state <= FIX;
                end
                FIX: begin
                    r_prod  <= r_sign ? (~r_p + 8'd1) : r_p;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_count <= r_count + 8'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid = r_valid;
    assign resp_id    = r_id;
    assign resp_prod  = r_prod;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_count;

endmodule

// File: tb/tb_mult_s4_sched.sv
// Self-checking bench for mult_s4_sched: a scoreboard monitor pairs each
// accepted request with its response, and scenario tasks check timing,
// arbitration, bypass, backpressure, mid-operation reset and counter wrap.
module tb_mult_s4_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] reqValid;
    logic [1:0] reqReady;
    logic [3:0] x0, y0, x1, y1;
    logic       respValid;
    logic       respReady;
    logic       respId;
    logic [7:0] respProd;
    logic       busy;
    logic [7:0] opCount;

    logic [1:0] reqValidB;
    logic [1:0] reqReadyB;
    logic       respValidB;
    logic       respIdB;
    logic [7:0] respProdB;
    logic       busyB;
    logic [7:0] opCountB;

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    logic [7:0] expCount = 8'd0;

    typedef struct {
        logic       id;
        logic [7:0] prod;
    } exp_t;
    exp_t sb[$];

    mult_s4_sched #(.RR_INIT(0), .ZERO_BYPASS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_x0     (x0),
        .req_y0     (y0),
        .req_x1     (x1),
        .req_y1     (y1),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_id    (respId),
        .resp_prod  (respProd),
        .busy       (busy),
        .op_count   (opCount)
    );

    mult_s4_sched #(.RR_INIT(0), .ZERO_BYPASS(0)) dutNb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValidB),
        .req_ready  (reqReadyB),
        .req_x0     (x0),
        .req_y0     (y0),
        .req_x1     (x1),
        .req_y1     (y1),
        .resp_valid (respValidB),
        .resp_ready (respReady),
        .resp_id    (respIdB),
        .resp_prod  (respProdB),
        .busy       (busyB),
        .op_count   (opCountB)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Signed reference product, computed at full integer width.
    function automatic logic [7:0] refProd(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[7:0];
    endfunction

    // Scoreboard monitor, sampling one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            checks++;
            if (reqReady === 2'b11) begin
                errors++;
                $display("[TB] FAIL ready_onehot: req_ready=%b required one-hot or zero", reqReady);
            end
            if (reqValid[0] && reqReady[0]) sb.push_back('{1'b0, refProd(x0, y0)});
            if (reqValid[1] && reqReady[1]) sb.push_back('{1'b1, refProd(x1, y1)});
            if (respValid && respReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_empty: response id=%0d prod=%h with no request outstanding", respId, respProd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (respId !== e.id || respProd !== e.prod) begin
                        errors++;
                        $display("[TB] FAIL sb_resp: id=%0d prod=%h required id=%0d prod=%h", respId, respProd, e.id, e.prod);
                    end
                end
                checks++;
                if (opCount !== expCount) begin
                    errors++;
                    $display("[TB] FAIL op_count_pre: op_count=%0d required %0d", opCount, expCount);
                end
                expCount  = expCount + 8'd1;
                doneCount = doneCount + 1;
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: busy=%b required 0 within 40 cycles", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (reqReady !== 2'b00 || respValid !== 1'b0 || respId !== 1'b0 ||
            respProd !== 8'h00 || busy !== 1'b0 || opCount !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b valid=%b id=%b prod=%h busy=%b cnt=%0d required all zero",
                     reqReady, respValid, respId, respProd, busy, opCount);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        reqValid = 2'b11;
        x0 = 4'h8; y0 = 4'h8;
        x1 = 4'h8; y1 = 4'h7;
        for (int k = 0; k < 4; k++) begin
            wait_idle("rr");
            #1;
            checks++;
            if (reqReady !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: req_ready=%b required %b", k, reqReady,
                         (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            @(negedge clk);
        end
        reqValid = 2'b00;
        wait_idle("rr_end");
    endtask

    task automatic test_single();
        reqValid = 2'b01;
        x0 = 4'd3; y0 = 4'hE;
        #1;
        checks++;
        if (reqReady !== 2'b01 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready: ready=%b busy=%b required 01 and 0", reqReady, busy);
        end
        @(negedge clk);
        reqValid = 2'b00;
        x0 = 4'd7;
        checks++;
        if (busy !== 1'b1 || respValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_e0: busy=%b valid=%b required 1 and 0", busy, respValid);
        end
        @(negedge clk);
        checks++;
        if (respValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_e1: resp_valid=%b required 0", respValid);
        end
        @(negedge clk);
        checks++;
        if (respValid !== 1'b1 || respId !== 1'b0 || respProd !== 8'hFA || opCount !== expCount) begin
            errors++;
            $display("[TB] FAIL single_e2: valid=%b id=%b prod=%h cnt=%0d required 1 0 fa %0d",
                     respValid, respId, respProd, opCount, expCount);
        end
        @(negedge clk);
        checks++;
        if (respValid !== 1'b0 || busy !== 1'b0 || opCount !== expCount) begin
            errors++;
            $display("[TB] FAIL single_hs: valid=%b busy=%b cnt=%0d required 0 0 %0d",
                     respValid, busy, opCount, expCount);
        end
    endtask

    task automatic test_bypass();
        reqValid  = 2'b10;
        reqValidB = 2'b10;
        x1 = 4'd0; y1 = 4'hB;
        #1;
        checks++;
        if (reqReady !== 2'b10 || reqReadyB !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bypass_ready: ready=%b readyB=%b required 10 10", reqReady, reqReadyB);
        end
        @(negedge clk);
        reqValid  = 2'b00;
        reqValidB = 2'b00;
        x1 = 4'd3;
        checks++;
        if (respValid !== 1'b1 || respId !== 1'b1 || respProd !== 8'h00 || respValidB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass_e0: valid=%b id=%b prod=%h validB=%b required 1 1 00 0",
                     respValid, respId, respProd, respValidB);
        end
        @(negedge clk);
        checks++;
        if (respValid !== 1'b0 || respValidB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass_e1: valid=%b validB=%b required 0 0", respValid, respValidB);
        end
        @(negedge clk);
        checks++;
        if (respValidB !== 1'b1 || respIdB !== 1'b1 || respProdB !== 8'h00) begin
            errors++;
            $display("[TB] FAIL nobypass_e2: validB=%b idB=%b prodB=%h required 1 1 00",
                     respValidB, respIdB, respProdB);
        end
        @(negedge clk);
        checks++;
        if (respValidB !== 1'b0 || opCountB !== 8'd1) begin
            errors++;
            $display("[TB] FAIL nobypass_hs: validB=%b cntB=%0d required 0 1", respValidB, opCountB);
        end
    endtask

    task automatic test_backpressure();
        int n;
        respReady = 1'b0;
        reqValid  = 2'b11;
        x0 = 4'd5; y0 = 4'hD;
        x1 = 4'd2; y1 = 4'd2;
        #1;
        checks++;
        if (reqReady !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_grant: req_ready=%b required 01", reqReady);
        end
        n = 0;
        @(negedge clk);
        while (!respValid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (respValid !== 1'b1 || respId !== 1'b0 || respProd !== 8'hF1 || reqReady !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: valid=%b id=%b prod=%h ready=%b required 1 0 f1 00",
                         k, respValid, respId, respProd, reqReady);
            end
            @(negedge clk);
        end
        respReady = 1'b1;
        reqValid  = 2'b00;
        @(negedge clk);
        wait_idle("bp");
    endtask

    task automatic test_reset_mid();
        reqValid = 2'b01;
        x0 = 4'd7; y0 = 4'h9;
        @(negedge clk);
        reqValid = 2'b00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_fix_busy: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (reqReady !== 2'b00 || respValid !== 1'b0 || respId !== 1'b0 ||
            respProd !== 8'h00 || busy !== 1'b0 || opCount !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid: ready=%b valid=%b id=%b prod=%h busy=%b cnt=%0d required all zero",
                     reqReady, respValid, respId, respProd, busy, opCount);
        end
        sb.delete();
        expCount = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (respValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_no_resp%0d: resp_valid=%b required 0", k, respValid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int target;
        int cyc;
        target = doneCount + 256;
        cyc = 0;
        reqValid = 2'b11;
        while (doneCount < target && cyc < 3000) begin
            x0 = 4'($urandom_range(0, 15));
            y0 = 4'($urandom_range(0, 15));
            x1 = 4'($urandom_range(0, 15));
            y1 = 4'($urandom_range(0, 15));
            @(negedge clk);
            cyc++;
        end
        reqValid = 2'b00;
        checks++;
        if (doneCount < target) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: completed=%0d required %0d", doneCount, target);
        end
        checks++;
        if (opCount !== 8'd0 || busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_wrap: op_count=%0d busy=%b pending=%0d required 0 0 0",
                     opCount, busy, sb.size());
        end
    endtask

    initial begin
        reqValid  = 2'b00;
        reqValidB = 2'b00;
        respReady = 1'b1;
        x0 = 4'd0; y0 = 4'd0; x1 = 4'd0; y1 = 4'd0;
        test_reset();
        test_round_robin();
        test_single();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
